// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file with registered reads, write-first bypass,
// highest-index write priority, optional hardwired-zero entry 0 and a post-reset clear sequencer.
module regfile_multiport #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       init_busy,
    input  logic [NUM_RD-1:0]          read_en,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rvalid,
    input  logic [NUM_WR-1:0]          write_en,
    input  logic [NUM_WR*ADDR_W-1:0]   waddr,
    input  logic [NUM_WR*DATA_W-1:0]   wdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {StClear, StReady} state_e;

    state_e                     r_state;
    logic [ADDR_W-1:0]          r_clr_ptr;
    logic                       r_init_busy;
    logic [NUM_RD*DATA_W-1:0]   r_rdata;
    logic [NUM_RD-1:0]          r_rvalid;
    logic [DATA_W-1:0]          r_mem [DEPTH];
    logic [DATA_W-1:0]          w_rd_val [NUM_RD];

    // Array storage: the clear sequencer owns the write path until READY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == StClear) begin
                r_mem[r_clr_ptr] <= '0;
            end else begin
                // Ascending loop: a higher port's assignment overrides a lower one.
                for (int j = 0; j < NUM_WR; j++) begin
                    if (write_en[j] &&
                        !(ZERO_REG && (waddr[j*ADDR_W +: ADDR_W] == '0))) begin
                        r_mem[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            w_rd_val[i] = r_mem[raddr[i*ADDR_W +: ADDR_W]];
            for (int j = 0; j < NUM_WR; j++) begin
                if (write_en[j] && (waddr[j*ADDR_W +: ADDR_W] == raddr[i*ADDR_W +: ADDR_W])) begin
                    w_rd_val[i] = wdata[j*DATA_W +: DATA_W];
                end
            end
            if (ZERO_REG && (raddr[i*ADDR_W +: ADDR_W] == '0)) begin
                w_rd_val[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StClear;
            r_clr_ptr   <= '0;
            r_init_busy <= 1'b1;
            r_rdata     <= '0;
            r_rvalid    <= '0;
        end else begin
            case (r_state)
                StClear: begin
                    r_rvalid  <= '0;
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (&r_clr_ptr) begin
                        r_state     <= StReady;
                        r_init_busy <= 1'b0;
                    end
                end
                StReady: begin
                    r_rvalid <= read_en;
                    for (int i = 0; i < NUM_RD; i++) begin
                        if (read_en[i]) begin
                            r_rdata[i*DATA_W +: DATA_W] <= w_rd_val[i];
                        end
                    end
                end
                default: begin
                    r_state <= StClear;
                end
            endcase
        end
    end

    assign init_busy = r_init_busy;
    assign rdata     = r_rdata;
    assign rvalid    = r_rvalid;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport; a second instance is built with
// ZERO_REG=1 and shares all inputs with the default instance.
module tb_regfile_multiport;

    logic         clk;
    logic         reset;
    logic [1:0]   read_en;
    logic [11:0]  raddr;
    logic [1:0]   write_en;
    logic [11:0]  waddr;
    logic [127:0] wdata;

    logic         init_busy;
    logic [127:0] rdata;
    logic [1:0]   rvalid;
    logic         z_init_busy;
    logic [127:0] z_rdata;
    logic [1:0]   z_rvalid;

    int n_pass;
    int n_total;

    regfile_multiport #(
        .DATA_W(64), .ADDR_W(6), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .init_busy(init_busy),
        .read_en(read_en), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
        .write_en(write_en), .waddr(waddr), .wdata(wdata)
    );

    regfile_multiport #(
        .DATA_W(64), .ADDR_W(6), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1)
    ) dutz (
        .clk(clk), .reset(reset), .init_busy(z_init_busy),
        .read_en(read_en), .raddr(raddr), .rdata(z_rdata), .rvalid(z_rvalid),
        .write_en(write_en), .waddr(waddr), .wdata(wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        read_en  = '0;
        write_en = '0;
        raddr    = '0;
        waddr    = '0;
        wdata    = '0;
    endtask

    task automatic wr0(input logic [5:0] a, input logic [63:0] d);
        write_en = 2'b01;
        waddr[5:0] = a;
        wdata[63:0] = d;
        tick();
        write_en = '0;
    endtask

    task automatic rd_both(input logic [5:0] a);
        read_en = 2'b11;
        raddr = {a, a};
        tick();
        read_en = '0;
    endtask

    // Reset pulse followed by a bounded count of cycles with init_busy high.
    task automatic reset_and_count(output int cnt);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cnt = 0;
        while (init_busy && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    task automatic test_reset();
        int cnt;
        reset = 1'b1;
        idle();
        tick();
        n_total++;
        if (init_busy !== 1'b1 || rvalid !== 2'b00 || rdata !== 128'h0) begin
            $display("FAIL reset_state: busy=%b rvalid=%b rdata=%h, need busy=1 rvalid=00 rdata=0",
                     init_busy, rvalid, rdata);
        end else n_pass++;
        reset = 1'b0;
        cnt = 0;
        while (init_busy && cnt < 200) begin
            tick();
            cnt++;
        end
        n_total++;
        if (cnt !== 64) $display("FAIL first_clear_len: got %0d cycles, need 64", cnt);
        else n_pass++;

        wr0(6'd5, 64'hDEAD_BEEF);
        wr0(6'd63, 64'hDEAD_BEEF);
        rd_both(6'd5);
        n_total++;
        if (rdata[63:0] !== 64'hDEAD_BEEF) begin
            $display("FAIL preload_5: got %h need %h", rdata[63:0], 64'hDEAD_BEEF);
        end else n_pass++;

        reset_and_count(cnt);
        n_total++;
        if (cnt !== 64) $display("FAIL clear_len: got %0d cycles, need 64", cnt);
        else n_pass++;

        rd_both(6'd5);
        n_total++;
        if (rvalid !== 2'b11 || rdata !== 128'h0) begin
            $display("FAIL cleared_5: rvalid=%b rdata=%h, need 11 and 0", rvalid, rdata);
        end else n_pass++;
        rd_both(6'd63);
        n_total++;
        if (rvalid !== 2'b11 || rdata !== 128'h0) begin
            $display("FAIL cleared_63: rvalid=%b rdata=%h, need 11 and 0", rvalid, rdata);
        end else n_pass++;

        tick();
        n_total++;
        if (rvalid !== 2'b00) $display("FAIL rvalid_pulse: got %b need 00", rvalid);
        else n_pass++;
    endtask

    task automatic test_walk();
        logic [63:0] d;
        int errs;
        errs = 0;
        for (int a = 0; a < 64; a++) begin
            d = {$urandom, $urandom};
            wr0(6'(a), d);
            rd_both(6'(a));
            n_total++;
            if (rvalid !== 2'b11 || rdata[63:0] !== d || rdata[127:64] !== d) begin
                $display("FAIL walk_%0d: rvalid=%b rdata=%h, need 11 and %h on both ports",
                         a, rvalid, rdata, d);
            end else n_pass++;
        end
    endtask

    task automatic test_bypass();
        wr0(6'd10, 64'h0BAD_0BAD);
        write_en = 2'b01;
        waddr[5:0] = 6'd10;
        wdata[63:0] = 64'h1234;
        read_en = 2'b01;
        raddr[5:0] = 6'd10;
        tick();
        idle();
        n_total++;
        if (rvalid !== 2'b01 || rdata[63:0] !== 64'h1234) begin
            $display("FAIL bypass: rvalid=%b rdata0=%h, need 01 and 1234", rvalid, rdata[63:0]);
        end else n_pass++;
        // read_en low: data holds, strobe drops
        tick();
        n_total++;
        if (rvalid !== 2'b00 || rdata[63:0] !== 64'h1234) begin
            $display("FAIL hold: rvalid=%b rdata0=%h, need 00 and 1234", rvalid, rdata[63:0]);
        end else n_pass++;
        rd_both(6'd10);
        n_total++;
        if (rdata[127:64] !== 64'h1234) begin
            $display("FAIL bypass_stored: got %h need 1234", rdata[127:64]);
        end else n_pass++;
    endtask

    task automatic test_conflict();
        write_en = 2'b11;
        waddr = {6'd20, 6'd20};
        wdata = {64'h5555, 64'hAAAA};
        read_en = 2'b10;
        raddr = {6'd20, 6'd0};
        tick();
        idle();
        n_total++;
        if (rdata[127:64] !== 64'h5555) begin
            $display("FAIL conflict_bypass: got %h need 5555", rdata[127:64]);
        end else n_pass++;
        rd_both(6'd20);
        n_total++;
        if (rdata[63:0] !== 64'h5555) begin
            $display("FAIL conflict_stored: got %h need 5555", rdata[63:0]);
        end else n_pass++;
    endtask

    task automatic test_zero_reg();
        write_en = 2'b01;
        waddr[5:0] = 6'd0;
        wdata[63:0] = 64'hFFFF;
        read_en = 2'b01;
        raddr[5:0] = 6'd0;
        tick();
        idle();
        n_total++;
        if (z_rvalid !== 2'b01 || z_rdata[63:0] !== 64'h0) begin
            $display("FAIL zero_bypass: rvalid=%b rdata0=%h, need 01 and 0", z_rvalid, z_rdata[63:0]);
        end else n_pass++;
        n_total++;
        if (rdata[63:0] !== 64'hFFFF) begin
            $display("FAIL nonzero_bypass: got %h need ffff", rdata[63:0]);
        end else n_pass++;
        rd_both(6'd0);
        n_total++;
        if (z_rdata !== 128'h0) $display("FAIL zero_stored: got %h need 0", z_rdata);
        else n_pass++;
        n_total++;
        if (rdata[63:0] !== 64'hFFFF) begin
            $display("FAIL nonzero_stored: got %h need ffff", rdata[63:0]);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        wr0(6'd3, 64'h3333);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 30; k++) tick();
        n_total++;
        if (init_busy !== 1'b1) $display("FAIL busy_mid_clear: got %b need 1", init_busy);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cnt = 0;
        while (init_busy && cnt < 200) begin
            if (cnt == 40) begin
                write_en = 2'b01;
                waddr[5:0] = 6'd3;
                wdata[63:0] = 64'hCAFE;
                read_en = 2'b11;
                raddr = {6'd3, 6'd3};
            end
            tick();
            cnt++;
            if (cnt == 41) begin
                n_total++;
                if (rvalid !== 2'b00 || rdata !== 128'h0) begin
                    $display("FAIL read_in_clear: rvalid=%b rdata=%h, need 00 and 0", rvalid, rdata);
                end else n_pass++;
                idle();
            end
        end
        n_total++;
        if (cnt !== 64) $display("FAIL restart_len: got %0d cycles, need 64", cnt);
        else n_pass++;
        rd_both(6'd3);
        n_total++;
        if (rvalid !== 2'b11 || rdata !== 128'h0) begin
            $display("FAIL write_in_clear: rvalid=%b rdata=%h, need 11 and 0", rvalid, rdata);
        end else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_walk();
        test_bypass();
        test_conflict();
        test_zero_reg();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
